pkt_leaf_rx: RTL and testbench

- Clocked leaf-end receiver that terminates one router child output port and hands packets to the local neuron PE.
- Sender side uses 4-phase bundled-data req/ack with 47-bit packets: {dest_addr[46:44], source_addr[43:41], payload[40:0]}.
- Synchronizes req, captures the packet, filters on destination address, buffers in a small FIFO, and presents source + payload to the PE with valid/ready.

---
 rtl/pkt_leaf_rx.sv | 118 +++++++++++
 tb/tb_pkt_leaf_rx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_leaf_rx.sv
// Leaf receiver: 4-phase req/ack capture, address filter, FWFT FIFO to PE.
// Ports: clk, rst (sync, active-high); pkt_req/pkt_data/pkt_ack (sender);
//   out_valid/out_ready/out_src/out_payload (PE); fifo_count, drop_count.
module pkt_leaf_rx #(
  parameter int                    WIDTH      = 47,
  parameter int                    WIDTH_ADDR = 3,
  parameter logic [WIDTH_ADDR-1:0] ADDRESS    = '0,
  parameter int                    DEPTH      = 4,
  parameter int                    CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pkt_req,
  input  logic [WIDTH-1:0]              pkt_data,
  output logic                          pkt_ack,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH_ADDR-1:0]         out_src,
  output logic [WIDTH-2*WIDTH_ADDR-1:0] out_payload,
  output logic [$clog2(DEPTH):0]        fifo_count,
  output logic [CNT_WIDTH-1:0]          drop_count
);

  localparam int PW = WIDTH - WIDTH_ADDR;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_ACK
  } state_t;

  state_t               r_state;
  logic                 r_req_s1;
  logic                 r_req_s2;
  logic                 r_ack;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [CNT_WIDTH-1:0] r_drop;
  logic [PW-1:0]        r_mem [DEPTH];

  logic                 w_match;
  logic                 w_push;
  logic                 w_pop;
  logic [PW-1:0]        w_head;

  assign w_match = pkt_data[WIDTH-1 -: WIDTH_ADDR] == ADDRESS;
  assign w_push  = (r_state == S_CAPTURE) && w_match;
  assign w_pop   = (r_count != '0) && out_ready;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_req_s1 <= 1'b0;
      r_req_s2 <= 1'b0;
      r_ack    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
    end else begin
      r_req_s1 <= pkt_req;
      r_req_s2 <= r_req_s1;

      unique case (r_state)
        S_IDLE: begin
          // Full FIFO: ack is withheld, sender stalls.
          if (r_req_s2 && (r_count < CW'(DEPTH)))
            r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_state <= S_ACK;
          r_ack   <= 1'b1;
          if (!w_match && (r_drop != '1))
            r_drop <= r_drop + 1'b1;
        end
        S_ACK: begin
          if (!r_req_s2) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
        end
      endcase

      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset; pointer reset makes old entries unreachable.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= pkt_data[PW-1:0];
  end

  assign pkt_ack     = r_ack;
  assign out_valid   = r_count != '0;
  assign out_src     = w_head[PW-1 -: WIDTH_ADDR];
  assign out_payload = w_head[PW-WIDTH_ADDR-1:0];
  assign fifo_count  = r_count;
  assign drop_count  = r_drop;

endmodule

// File: tb/tb_pkt_leaf_rx.sv
// Scoreboard bench for pkt_leaf_rx: random and directed packets,
// expected PE output queued at issue, checked by a pop monitor.
module tb_pkt_leaf_rx;

  localparam int         W    = 47;
  localparam int         WA   = 3;
  localparam int         WP   = W - 2*WA;
  localparam int         D    = 4;
  localparam int         CNTW = 8;
  localparam logic [2:0] ADDR = 3'b000;
  localparam int         SATV = (1 << CNTW) - 1;

  logic          clk;
  logic          rst;
  logic          pkt_req;
  logic [W-1:0]  pkt_data;
  logic          pkt_ack;
  logic          out_valid;
  logic          out_ready;
  logic [WA-1:0] out_src;
  logic [WP-1:0] out_payload;
  logic [$clog2(D):0] fifo_count;
  logic [CNTW-1:0] drop_count;

  pkt_leaf_rx #(
    .WIDTH(W),
    .WIDTH_ADDR(WA),
    .ADDRESS(ADDR),
    .DEPTH(D),
    .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pkt_req(pkt_req),
    .pkt_data(pkt_data),
    .pkt_ack(pkt_ack),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_src(out_src),
    .out_payload(out_payload),
    .fifo_count(fifo_count),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int m_drops;
  bit rand_rdy;
  logic [W-WA-1:0] exp_q [$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic monitor_loop();
    logic [W-WA-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected got %0h expected none",
                   {out_src, out_payload});
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", 64'({out_src, out_payload}), 64'(e));
        end
      end
    end
  endtask

  function automatic void model_issue(input logic [2:0] d,
                                      input logic [2:0] s,
                                      input logic [WP-1:0] p);
    if (d == ADDR) exp_q.push_back({s, p});
    else if (m_drops < SATV) m_drops++;
  endfunction

  task automatic wait_ack(input logic lvl, input int maxc,
                          input string nm);
    int n;
    n = 0;
    while (pkt_ack !== lvl && n < maxc) begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    chk(nm, 64'(pkt_ack), 64'(lvl));
  endtask

  task automatic send(input logic [2:0] d, input logic [2:0] s,
                      input logic [WP-1:0] p);
    pkt_data = {d, s, p};
    model_issue(d, s, p);
    pkt_req = 1'b1;
    wait_ack(1'b1, 60, "ack_rise");
    pkt_req = 1'b0;
    wait_ack(1'b0, 20, "ack_fall");
    chk("drop_count", 64'(drop_count), 64'(m_drops));
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b0;
    chk("drain_q", 64'(exp_q.size()), 64'd0);
    chk("drain_count", 64'(fifo_count), 64'd0);
  endtask

  function automatic logic [WP-1:0] rpay();
    return WP'({$urandom(), $urandom()});
  endfunction

  initial begin
    checks    = 0;
    errors    = 0;
    m_drops   = 0;
    rand_rdy  = 1'b0;
    rst       = 1'b1;
    pkt_req   = 1'b0;
    pkt_data  = '0;
    out_ready = 1'b0;
    fork
      monitor_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 64'(pkt_ack), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single accept with exact ack timing.
    pkt_data = {3'b000, 3'b100, {WP{1'b1}}};
    model_issue(3'b000, 3'b100, {WP{1'b1}});
    pkt_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("lat_ack_e3", 64'(pkt_ack), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_ack_e4", 64'(pkt_ack), 64'd1);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_src", 64'(out_src), 64'd4);
    chk("lat_pay", 64'(out_payload), 64'h1FF_FFFF_FFFF);
    chk("lat_count", 64'(fifo_count), 64'd1);
    pkt_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("fall_e2", 64'(pkt_ack), 64'd1);
    @(posedge clk);
    #1;
    chk("fall_e3", 64'(pkt_ack), 64'd0);
    drain();

    // Address filter.
    send(3'b001, 3'b000, rpay());
    chk("filt_valid", 64'(out_valid), 64'd0);
    send(3'b000, 3'b101, rpay());
    chk("filt_count", 64'(fifo_count), 64'd1);
    drain();

    // Ready while empty.
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("empty_valid", 64'(out_valid), 64'd0);
    chk("empty_count", 64'(fifo_count), 64'd0);
    out_ready = 1'b0;

    // Back-pressure: fifth packet waits for space.
    for (int i = 1; i <= 4; i++)
      send(ADDR, 3'($urandom()), WP'(i));
    chk("bp_count", 64'(fifo_count), 64'd4);
    pkt_data = {ADDR, 3'b011, WP'(5)};
    model_issue(ADDR, 3'b011, WP'(5));
    pkt_req = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("bp_no_ack", 64'(pkt_ack), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    wait_ack(1'b1, 20, "bp_ack");
    pkt_req = 1'b0;
    wait_ack(1'b0, 20, "bp_ack_fall");
    chk("bp_count2", 64'(fifo_count), 64'd4);
    drain();

    // Push and pop on the same edge.
    send(ADDR, 3'b001, rpay());
    send(ADDR, 3'b010, rpay());
    pkt_data = {ADDR, 3'b110, WP'(77)};
    model_issue(ADDR, 3'b110, WP'(77));
    pkt_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("sim_count", 64'(fifo_count), 64'd2);
    chk("sim_ack", 64'(pkt_ack), 64'd1);
    pkt_req = 1'b0;
    wait_ack(1'b0, 20, "sim_ack_fall");
    drain();

    // Randomized traffic with random ready.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [2:0] d;
      d = ($urandom_range(0, 1) == 0) ? ADDR : 3'($urandom());
      send(d, 3'($urandom()), rpay());
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    drain();

    // Drop counter saturation.
    for (int i = 0; i < SATV + 5; i++)
      send(3'b111, 3'($urandom()), rpay());
    chk("sat_drop", 64'(drop_count), 64'(SATV));

    // Reset in ACK with two entries.
    send(ADDR, 3'b001, rpay());
    pkt_data = {ADDR, 3'b010, rpay()};
    pkt_req = 1'b1;
    wait_ack(1'b1, 20, "rst_mid_ack");
    chk("pre_rst_count", 64'(fifo_count), 64'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ack", 64'(pkt_ack), 64'd0);
    chk("mid_rst_count", 64'(fifo_count), 64'd0);
    chk("mid_rst_drop", 64'(drop_count), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    m_drops = 0;
    pkt_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    send(ADDR, 3'b111, rpay());
    chk("post_rst_count", 64'(fifo_count), 64'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
